// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and helpers for the stream multiplexer
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rtl/stream_mux_rr_pick.sv - round-robin picker: first valid channel above ptr, wrapping
module stream_mux_rr_pick #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;

  always_comb begin
    dbl = {valid, valid};
    // bit 0 of rot is channel ptr+1; a shift of N lands back on channel 0
    rot = N'(dbl >> (int'(ptr) + 1));
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    idx = SW'((int'(ptr) + 1 + off) % N);
    any = |valid;
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel valid/ready stream mux with packet locking and one output register
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_en,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  state_t             state, nstate;
  logic [SEL_W-1:0]   rr_ptr, lock_chan;
  logic [SEL_W-1:0]   rr_idx, cand;
  logic               rr_any;
  logic               load_en, cand_ok, cand_last, xfer;
  logic [WIDTH-1:0]   cand_data;

  stream_mux_rr_pick #(.N(CHANNELS), .SW(SEL_W)) u_rr_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign load_en = ~out_valid | out_ready;

  always_comb begin
    cand      = '0;
    cand_ok   = 1'b0;
    cand_last = 1'b0;
    cand_data = '0;
    if (state == LOCKED) cand = lock_chan;
    else if (rr_en)      cand = rr_idx;
    else                 cand = sel;
    // an out-of-range select matches no channel, so nothing is granted
    for (int i = 0; i < CHANNELS; i++) begin
      if (cand == SEL_W'(i)) begin
        cand_ok   = in_valid[i];
        cand_last = in_last[i];
        cand_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n & load_en & cand_ok & (cand == SEL_W'(i));
    end
  end

  assign xfer = rst_n & load_en & cand_ok;

  always_comb begin
    nstate = state;
    if (xfer) begin
      if (state == IDLE && !cand_last)  nstate = LOCKED;
      if (state == LOCKED && cand_last) nstate = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
      lock_chan <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      state <= nstate;
      if (xfer && state == IDLE) begin
        rr_ptr    <= cand;
        lock_chan <= cand;
      end
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= cand_data;
          out_last <= cand_last;
          out_chan <= cand;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed self-checking bench for stream_mux in three configurations
module tb_stream_mux;

  logic clk, rst_n;
  int   vectors, miscompares;

  // A: WIDTH=1, CHANNELS=2
  logic [1:0] a_data, a_valid, a_last, a_ready;
  logic [0:0] a_sel, a_odata, a_ochan;
  logic       a_rr, a_ovalid, a_olast, a_oready;
  // B: WIDTH=8, CHANNELS=4
  logic [31:0] b_data;
  logic [3:0]  b_valid, b_last, b_ready;
  logic [1:0]  b_sel, b_ochan;
  logic [7:0]  b_odata;
  logic        b_rr, b_ovalid, b_olast, b_oready;
  // C: WIDTH=8, CHANNELS=3
  logic [23:0] c_data;
  logic [2:0]  c_valid, c_last, c_ready;
  logic [1:0]  c_sel, c_ochan;
  logic [7:0]  c_odata;
  logic        c_rr, c_ovalid, c_olast, c_oready;

  stream_mux #(.WIDTH(1), .CHANNELS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(a_ready), .sel(a_sel), .rr_en(a_rr), .out_data(a_odata), .out_valid(a_ovalid),
    .out_last(a_olast), .out_chan(a_ochan), .out_ready(a_oready));

  stream_mux #(.WIDTH(8), .CHANNELS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .sel(b_sel), .rr_en(b_rr), .out_data(b_odata), .out_valid(b_ovalid),
    .out_last(b_olast), .out_chan(b_ochan), .out_ready(b_oready));

  stream_mux #(.WIDTH(8), .CHANNELS(3)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
    .in_ready(c_ready), .sel(c_sel), .rr_en(c_rr), .out_data(c_odata), .out_valid(c_ovalid),
    .out_last(c_olast), .out_chan(c_ochan), .out_ready(c_oready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_data = '0; a_valid = '0; a_last = '0; a_sel = '0; a_rr = 1'b0; a_oready = 1'b1;
    b_data = '0; b_valid = 4'hF; b_last = '0; b_sel = '0; b_rr = 1'b0; b_oready = 1'b1;
    c_data = '0; c_valid = '0; c_last = '0; c_sel = '0; c_rr = 1'b0; c_oready = 1'b1;
    tick();
    vectors++; if (b_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid got=%b exp=0", b_ovalid); end
    vectors++; if (b_odata !== 8'h00) begin miscompares++; $display("FAIL reset_b_data got=%h exp=00", b_odata); end
    vectors++; if (b_ochan !== 2'd0) begin miscompares++; $display("FAIL reset_b_chan got=%0d exp=0", b_ochan); end
    vectors++; if (b_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_b_ready got=%b exp=0000", b_ready); end
    vectors++; if (a_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_ac_valid got=%b%b exp=00", a_ovalid, c_ovalid); end
    b_valid = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fixed;
    a_rr = 1'b0; a_sel = 1'b1; a_valid = 2'b11; a_data = 2'b10; a_last = 2'b11; a_oready = 1'b1;
    #1;
    vectors++; if (a_ready !== 2'b10) begin miscompares++; $display("FAIL fixed_ready got=%b exp=10", a_ready); end
    tick();
    vectors++; if ({a_ovalid, a_odata, a_ochan, a_olast} !== 4'b1111) begin miscompares++; $display("FAIL fixed_out got=v%b d%b c%b l%b exp=v1 d1 c1 l1", a_ovalid, a_odata, a_ochan, a_olast); end
    a_valid = 2'b00;
    tick();
    vectors++; if (a_ovalid !== 1'b0) begin miscompares++; $display("FAIL fixed_drain got=%b exp=0", a_ovalid); end
  endtask

  task automatic test_lock;
    b_rr = 1'b0; b_sel = 2'd0; b_oready = 1'b1;
    b_valid = 4'b0011; b_last = 4'b0010; b_data = {8'h00, 8'h00, 8'hB1, 8'hA1};
    #1;
    vectors++; if (b_ready !== 4'b0001) begin miscompares++; $display("FAIL lock_a1_ready got=%b exp=0001", b_ready); end
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan, b_olast} !== {1'b1, 8'hA1, 2'd0, 1'b0}) begin miscompares++; $display("FAIL lock_a1 got=v%b d%h c%0d l%b exp=v1 dA1 c0 l0", b_ovalid, b_odata, b_ochan, b_olast); end
    b_sel = 2'd1; b_data[7:0] = 8'hA2;
    #1;
    vectors++; if (b_ready !== 4'b0001) begin miscompares++; $display("FAIL lock_held_ready got=%b exp=0001", b_ready); end
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan} !== {1'b1, 8'hA2, 2'd0}) begin miscompares++; $display("FAIL lock_a2 got=v%b d%h c%0d exp=v1 dA2 c0", b_ovalid, b_odata, b_ochan); end
    b_valid = 4'b0010;
    #1;
    vectors++; if (b_ready !== 4'b0000) begin miscompares++; $display("FAIL lock_gap_ready got=%b exp=0000", b_ready); end
    tick();
    vectors++; if (b_ovalid !== 1'b0) begin miscompares++; $display("FAIL lock_gap_valid got=%b exp=0", b_ovalid); end
    b_valid = 4'b0011; b_data[7:0] = 8'hA3; b_last = 4'b0011;
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan, b_olast} !== {1'b1, 8'hA3, 2'd0, 1'b1}) begin miscompares++; $display("FAIL lock_a3 got=v%b d%h c%0d l%b exp=v1 dA3 c0 l1", b_ovalid, b_odata, b_ochan, b_olast); end
    b_valid = 4'b0010;
    #1;
    vectors++; if (b_ready !== 4'b0010) begin miscompares++; $display("FAIL lock_release_ready got=%b exp=0010", b_ready); end
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan} !== {1'b1, 8'hB1, 2'd1}) begin miscompares++; $display("FAIL lock_b1 got=v%b d%h c%0d exp=v1 dB1 c1", b_ovalid, b_odata, b_ochan); end
    b_valid = '0;
    tick();
  endtask

  task automatic test_rr_backpressure;
    logic [1:0] exp_chan;
    do_reset();
    b_rr = 1'b1; b_sel = 2'd3; b_oready = 1'b1;
    b_valid = 4'hF; b_last = 4'hF; b_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    vectors++; if (b_ready !== 4'b0001) begin miscompares++; $display("FAIL rr_first_ready got=%b exp=0001", b_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_chan = 2'(i % 4);
      vectors++; if ({b_ovalid, b_ochan, b_odata} !== {1'b1, exp_chan, 8'h10 + 8'(exp_chan)}) begin miscompares++; $display("FAIL rr_beat%0d got=v%b c%0d d%h exp=v1 c%0d d%h", i, b_ovalid, b_ochan, b_odata, exp_chan, 8'h10 + 8'(exp_chan)); end
    end
    b_oready = 1'b0;
    #1;
    vectors++; if (b_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready0 got=%b exp=0000", b_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if ({b_ovalid, b_ochan, b_odata, b_ready} !== {1'b1, 2'd0, 8'h10, 4'b0000}) begin miscompares++; $display("FAIL bp_hold%0d got=v%b c%0d d%h r%b exp=v1 c0 d10 r0000", i, b_ovalid, b_ochan, b_odata, b_ready); end
    end
    b_oready = 1'b1;
    #1;
    vectors++; if (b_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=0010", b_ready); end
    tick();
    vectors++; if ({b_ovalid, b_ochan} !== {1'b1, 2'd1}) begin miscompares++; $display("FAIL bp_after1 got=v%b c%0d exp=v1 c1", b_ovalid, b_ochan); end
    tick();
    vectors++; if ({b_ovalid, b_ochan} !== {1'b1, 2'd2}) begin miscompares++; $display("FAIL bp_after2 got=v%b c%0d exp=v1 c2", b_ovalid, b_ochan); end
    b_valid = '0;
    tick();
  endtask

  task automatic test_illegal_sel;
    c_rr = 1'b0; c_sel = 2'd3; c_valid = 3'b111; c_last = 3'b111; c_oready = 1'b1;
    c_data = {8'hC2, 8'hC1, 8'hC0};
    #1;
    vectors++; if (c_ready !== 3'b000) begin miscompares++; $display("FAIL illegal_ready got=%b exp=000", c_ready); end
    tick();
    vectors++; if (c_ovalid !== 1'b0) begin miscompares++; $display("FAIL illegal_valid1 got=%b exp=0", c_ovalid); end
    tick();
    vectors++; if (c_ovalid !== 1'b0) begin miscompares++; $display("FAIL illegal_valid2 got=%b exp=0", c_ovalid); end
    c_sel = 2'd2;
    #1;
    vectors++; if (c_ready !== 3'b100) begin miscompares++; $display("FAIL top_sel_ready got=%b exp=100", c_ready); end
    tick();
    vectors++; if ({c_ovalid, c_ochan, c_odata} !== {1'b1, 2'd2, 8'hC2}) begin miscompares++; $display("FAIL top_sel_out got=v%b c%0d d%h exp=v1 c2 dC2", c_ovalid, c_ochan, c_odata); end
    c_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    b_rr = 1'b0; b_sel = 2'd2; b_oready = 1'b1;
    b_valid = 4'b0100; b_last = 4'b0000; b_data = {8'h00, 8'hD1, 8'h00, 8'h55};
    tick();
    b_data[23:16] = 8'hD2;
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan} !== {1'b1, 8'hD2, 2'd2}) begin miscompares++; $display("FAIL mid_beat2 got=v%b d%h c%0d exp=v1 dD2 c2", b_ovalid, b_odata, b_ochan); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({b_ovalid, b_odata, b_ochan, b_ready} !== {1'b0, 8'h00, 2'd0, 4'b0000}) begin miscompares++; $display("FAIL mid_async_reset got=v%b d%h c%0d r%b exp=v0 d00 c0 r0000", b_ovalid, b_odata, b_ochan, b_ready); end
    tick();
    b_rr = 1'b1; b_valid = 4'b0101; b_last = 4'b1111;
    #2;
    rst_n = 1'b1;
    #1;
    vectors++; if (b_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_grant got=%b exp=0001", b_ready); end
    tick();
    vectors++; if ({b_ovalid, b_odata, b_ochan} !== {1'b1, 8'h55, 2'd0}) begin miscompares++; $display("FAIL mid_first_beat got=v%b d%h c%0d exp=v1 d55 c0", b_ovalid, b_odata, b_ochan); end
    tick();
    vectors++; if ({b_ovalid, b_ochan} !== {1'b1, 2'd2}) begin miscompares++; $display("FAIL mid_second_beat got=v%b c%0d exp=v1 c2", b_ovalid, b_ochan); end
    b_valid = '0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fixed();
    test_lock();
    test_rr_backpressure();
    test_illegal_sel();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
